// File: rtl/uart_datamemload.sv
// UART receiver that preloads data memory over the datamem controller port.
// 8N1 bytes arriving on RX are packed little-endian into 32-bit words and
// written to consecutive word addresses starting at 0; after NUM_WORDS words
// the block parks in DONE until reset.
module uart_datamemload #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_WORDS    = 2048
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        RX,
  output logic [10:0] con_addr,
  output logic [3:0]  con_write,
  output logic [31:0] con_in,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;

  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [10:0]   LAST_ADDR = 11'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic          rx_s1;
  logic          rx_s2;
  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [1:0]    byte_k;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
    end
  end

  // Receive FSM: bit timing, byte assembly, word write and completion
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_k    <= '0;
      con_addr  <= '0;
      con_write <= '0;
      con_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s2) begin
            state   <= S_START;
            bit_cnt <= HALF_BIT;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (!rx_s2) begin
            state   <= S_DATA;
            bit_cnt <= FULL_BIT;
            bit_idx <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= FULL_BIT;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            busy <= 1'b0;
            if (rx_s2) begin
              con_in[{byte_k, 3'b000} +: 8] <= shift;
              byte_k <= byte_k + 1'b1;
              if (byte_k == 2'd3) begin
                state     <= S_WRITE;
                con_write <= '1;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s2) state <= S_IDLE;
        end
        S_WRITE: begin
          con_write <= '0;
          byte_k    <= '0;
          if (con_addr == LAST_ADDR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            con_addr <= con_addr + 1'b1;
            state    <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_datamemload.sv
// Randomized scoreboard bench for uart_datamemload (CLKS_PER_BIT=16, NUM_WORDS=4).
module tb_uart_datamemload;

  localparam int CPB = 16;
  localparam int NW  = 4;

  logic        CLK;
  logic        nrst;
  logic        RX;
  logic [10:0] con_addr;
  logic [3:0]  con_write;
  logic [31:0] con_in;
  logic        busy;
  logic        done;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [42:0] exp_q[$];     // {addr[10:0], data[31:0]}
  logic [7:0]  pend_q[$];
  int          m_ptr;
  bit          m_done;
  bit          m_ferr;

  uart_datamemload #(
    .CLKS_PER_BIT(CPB),
    .NUM_WORDS   (NW)
  ) dut (
    .CLK      (CLK),
    .nrst     (nrst),
    .RX       (RX),
    .con_addr (con_addr),
    .con_write(con_write),
    .con_in   (con_in),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse is matched against the oldest expected word
  always @(negedge CLK) begin
    if (nrst && con_write != 4'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h we=0x%0h", con_addr, con_in, con_write);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        if (con_write !== 4'hF || con_addr !== e[42:32] || con_in !== e[31:0]) begin
          failures++;
          $display("FAIL write: we=0x%0h addr=%0d data=0x%08h expected we=0xf addr=%0d data=0x%08h",
                   con_write, con_addr, con_in, e[42:32], e[31:0]);
        end
      end
    end
  end

  function automatic void model_reset();
    exp_q.delete();
    pend_q.delete();
    m_ptr  = 0;
    m_done = 0;
    m_ferr = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (m_done) return;
    if (!stop_ok) begin
      m_ferr = 1;
      return;
    end
    pend_q.push_back(b);
    if (pend_q.size() == 4) begin
      exp_q.push_back({11'(m_ptr), pend_q[3], pend_q[2], pend_q[1], pend_q[0]});
      pend_q.delete();
      if (m_ptr == NW - 1) m_done = 1;
      else m_ptr++;
    end
  endfunction

  task automatic do_reset();
    nrst = 1'b0;
    RX   = 1'b1;
    repeat (3) @(negedge CLK);
    model_reset();
    check("rst_addr", 32'(con_addr), 32'(0));
    check("rst_we", 32'(con_write), 32'(0));
    check("rst_data", con_in, 32'h0);
    check("rst_flags", {29'b0, busy, done, frame_err}, 32'h0);
    nrst = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // Drive one 8N1 frame; internal edges optionally displaced by up to +/-6 cycles
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit jitter, input int gap);
    int   edges[11];
    logic lvl;
    model_byte(b, stop_ok);
    edges[0]  = 0;
    edges[10] = 10 * CPB;
    for (int i = 1; i < 10; i++)
      edges[i] = i * CPB + (jitter ? int'($urandom_range(12)) - 6 : 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) lvl = 1'b0;
      else if (i == 9) lvl = stop_ok;
      else lvl = b[i-1];
      RX = lvl;
      repeat (edges[i+1] - edges[i]) @(negedge CLK);
    end
    if (stop_ok) repeat (gap) @(negedge CLK);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge CLK);
    check(name, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    nrst = 1'b1;
    RX   = 1'b1;
    model_reset();
    @(negedge CLK);
    do_reset();

    // basic word
    send_byte(8'h78, 1, 0, 2);
    send_byte(8'h56, 1, 0, 2);
    send_byte(8'h34, 1, 0, 2);
    send_byte(8'h12, 1, 0, 2);
    drain("word0_written");
    check("ptr_after_word0", 32'(con_addr), 32'(m_ptr));

    // fill all words, then done
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 0, $urandom_range(4));
    drain("fill_written");
    check("done_set", 32'(done), 32'(m_done));
    check("done_addr", 32'(con_addr), 32'(NW - 1));
    send_byte(8'h5A, 1, 0, 4);
    drain("no_write_after_done");
    check("done_sticky", 32'(done), 32'(1));

    // frame error, break, then recovery into the same word
    do_reset();
    send_byte(8'hAA, 0, 0, 0);
    RX = 1'b0;
    repeat (40) @(negedge CLK);
    RX = 1'b1;
    repeat (5) @(negedge CLK);
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("busy_in_break", 32'(busy), 32'(0));
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1, 0, 2);
    drain("after_ferr_written");
    check("frame_err_sticky", 32'(frame_err), 32'(1));

    // short glitch rejected
    do_reset();
    RX = 1'b0;
    repeat (4) @(negedge CLK);
    check("glitch_busy_rise", 32'(busy), 32'(1));
    @(negedge CLK);
    RX = 1'b1;
    repeat (20) @(negedge CLK);
    check("glitch_busy_fall", 32'(busy), 32'(0));
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255)), 1, 0, 1);
    drain("after_glitch_written");

    // reset mid-stream discards partial word
    do_reset();
    send_byte(8'h11, 1, 0, 1);
    send_byte(8'h22, 1, 0, 1);
    do_reset();
    send_byte(8'hDE, 1, 0, 1);
    send_byte(8'hAD, 1, 0, 1);
    send_byte(8'hBE, 1, 0, 1);
    send_byte(8'hEF, 1, 0, 1);
    drain("after_reset_written");
    check("after_reset_flags", {29'b0, busy, done, frame_err}, 32'h0);

    // edge jitter with random data across all words
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(255)), 1, 1, $urandom_range(3));
    drain("jitter_written");
    check("jitter_done", 32'(done), 32'(m_done));
    check("jitter_no_ferr", 32'(frame_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_datamemload.md
Name: uart_datamemload

Overview:
- UART receiver that loads data memory over the datamem controller port (con_addr / con_write / con_in) from a host serial link.
- Counterpart of the UART data-memory dump transmitter.
- Receives 8N1 bytes on RX and packs every 4 bytes little-endian into a 32-bit word.
- Writes each word to consecutive word addresses starting at 0. Used to preload datamem before releasing the core.

Parameters:
- CLKS_PER_BIT, 5208, CLK cycles per UART bit (50 MHz / 9600 baud); must be >= 4.
- NUM_WORDS, 2048, number of words to load before asserting done; must be <= 2048.

Ports:
- CLK  input  1  system clock (50 MHz)
- nrst  input  1  asynchronous active-low reset
- RX  input  1  UART serial input; asynchronous to CLK; idle high
- con_addr  output  11  datamem word address; always equals the current word pointer
- con_write  output  4  datamem byte write enables; 4'hF for one cycle per word, else 4'h0
- con_in  output  32  word to write; byte 0 received is con_in[7:0]
- busy  output  1  high from start-bit detection until the byte completes (stop sample or glitch reject)
- done  output  1  high after word NUM_WORDS-1 is written; sticky until reset
- frame_err  output  1  sticky: a stop bit was sampled low

Behaviour:
- Reset (async, nrst=0): state IDLE; con_addr=0, con_write=0, con_in=0, busy=0, done=0, frame_err=0; byte counter=0; synchronizer flops=1.
- RX passes through a 2-flop synchronizer before any use. All timing below is measured on the synchronized signal.
- One down-counter, bit_cnt, times each bit. A 3-bit index counts data bits.
- IDLE: on synchronized RX=0, go to START, load CLKS_PER_BIT/2-1, busy=1.
- START: at count 0, resample.
  - RX=0: go to DATA, load CLKS_PER_BIT-1.
  - RX=1 (glitch): return to IDLE with busy=0 and no side effects.
- DATA: at each count 0, sample RX into the shift register LSB first and reload. After the 8th sample, go to STOP with CLKS_PER_BIT-1 loaded.
- STOP: at count 0, sample RX.
  - RX=1: the byte is valid. Place it in con_in lane [8*k+7:8*k], where k is the byte counter 0..3, then increment k. If k was 3, go to WRITE; otherwise go to IDLE.
  - RX=0: set frame_err, discard the byte (k unchanged), go to BREAK.
- BREAK: stay until synchronized RX=1, then go to IDLE. This prevents a break condition from being taken as start bits.
- WRITE (exactly one cycle):
  - con_write=4'hF; con_addr = current pointer; con_in = assembled word.
  - Next cycle: con_write=0, k=0.
  - If pointer == NUM_WORDS-1, go to DONE with done=1 and the pointer held. Otherwise increment the pointer and go to IDLE.
- Write pulse latency: the cycle after the 4th byte's stop-bit sample.
- con_in holds its value after WRITE until overwritten lane by lane. Only the con_write pulse qualifies it.
- DONE: absorbing state; RX is ignored; busy=0; con_write stays 0. Only reset leaves DONE.
- No pointer wrap: the pointer never exceeds NUM_WORDS-1, and the 11-bit con_addr never overflows.
- A partial word (fewer than 4 bytes) is never written. It stays pending until more bytes arrive or reset.
- A frame error does not advance the pointer or reset k. Subsequent good bytes continue filling the same word.
- Reset mid-frame or mid-WRITE: all state clears immediately. The pointer returns to 0, and any pending partial word is lost.
- RX falling in the same cycle WRITE completes: the falling edge is seen in IDLE on the next cycle. At most a 1-cycle start delay, which is well within the half-bit margin.

Test Plan (CLKS_PER_BIT=16, NUM_WORDS=4):
- Send bytes 0x78,0x56,0x34,0x12 → one cycle with con_write=4'hF, con_addr=0, con_in=32'h12345678; the next word goes to con_addr=1.
- Send 16 bytes 0x00..0x0F → writes 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C at addresses 0..3; done=1; a further byte produces no write.
- Send byte 0xAA with stop bit forced low, then hold RX low 40 cycles, then send 0x01,0x02,0x03,0x04 → frame_err=1; one write of 32'h04030201 at address 0.
- RX low pulse of 5 cycles (shorter than half a bit) → returns to IDLE; busy falls; no byte counted; the next 4 valid bytes still land at address 0.
- Assert nrst after 2 bytes mid-stream, release, send 4 bytes 0xDE,0xAD,0xBE,0xEF → con_addr=0, con_in=32'hEFBEADDE; all flags 0.
- Check bit-center sampling: RX transitions ±6 cycles from nominal edges → bytes still received correctly.
